// File: rtl/crossover_gene_merge.sv
// Streaming NEAT crossover: aligns two key-sorted parent gene streams by innovation key
// and emits the child genome on a registered valid/ready output stream.
module crossover_gene_merge #(
  parameter int unsigned KEY_W     = 16,
  parameter int unsigned GENE_W    = 64,
  parameter logic [7:0]  LFSR_SEED = 8'hA5,
  parameter logic [7:0]  HALF      = 8'h40
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              bias,
  input  logic              p1_valid,
  output logic              p1_ready,
  input  logic [KEY_W-1:0]  p1_key,
  input  logic [GENE_W-1:0] p1_gene,
  input  logic              p1_last,
  input  logic              p2_valid,
  output logic              p2_ready,
  input  logic [KEY_W-1:0]  p2_key,
  input  logic [GENE_W-1:0] p2_gene,
  input  logic              p2_last,
  output logic              child_valid,
  input  logic              child_ready,
  output logic [KEY_W-1:0]  child_key,
  output logic [GENE_W-1:0] child_gene,
  output logic              child_src,
  output logic              busy,
  output logic              done,
  output logic [7:0]        child_count
);

  localparam int unsigned LFSR_W = 8;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [1:0] {IDLE, MERGE, FLUSH} state_e;

  state_e              state_q, state_d;
  logic                bias_q, bias_d;
  logic                x1_q, x1_d;
  logic                x2_q, x2_d;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
  logic                cv_q, cv_d;
  logic [KEY_W-1:0]    ck_q, ck_d;
  logic [GENE_W-1:0]   cg_q, cg_d;
  logic                cs_q, cs_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                slot_free;
  logic                h1, h2;
  logic                take1, take2;
  logic                emit, emit_src;
  logic [LFSR_W-1:0]   lfsr_next;

  assign slot_free = !cv_q || child_ready;
  // A parent head only counts while that parent still has genes left.
  assign h1 = p1_valid && !x1_q;
  assign h2 = p2_valid && !x2_q;
  assign lfsr_next = {lfsr_q[LFSR_W-2:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  always_comb begin
    state_d  = state_q;
    bias_d   = bias_q;
    x1_d     = x1_q;
    x2_d     = x2_q;
    lfsr_d   = lfsr_q;
    cv_d     = cv_q;
    ck_d     = ck_q;
    cg_d     = cg_q;
    cs_d     = cs_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    take1    = 1'b0;
    take2    = 1'b0;
    emit     = 1'b0;
    emit_src = 1'b0;

    if (cv_q && child_ready) cv_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = MERGE;
          bias_d  = bias;
          cnt_d   = '0;
          x1_d    = 1'b0;
          x2_d    = 1'b0;
          lfsr_d  = LFSR_SEED;
          busy_d  = 1'b1;
        end
      end
      MERGE: begin
        if (x1_q && x2_q) begin
          state_d = FLUSH;
        end else if (slot_free && rst_n) begin
          if (h1 && h2) begin
            if (p1_key == p2_key) begin
              take1    = 1'b1;
              take2    = 1'b1;
              emit     = 1'b1;
              emit_src = (lfsr_q > HALF) ? ~bias_q : bias_q;
              lfsr_d   = lfsr_next;
            end else if (p1_key < p2_key) begin
              take1    = 1'b1;
              emit     = !bias_q;
              emit_src = 1'b0;
            end else begin
              take2    = 1'b1;
              emit     = bias_q;
              emit_src = 1'b1;
            end
          end else if (x1_q && h2) begin
            take2    = 1'b1;
            emit     = bias_q;
            emit_src = 1'b1;
          end else if (x2_q && h1) begin
            take1    = 1'b1;
            emit     = !bias_q;
            emit_src = 1'b0;
          end
        end
      end
      FLUSH: begin
        if (slot_free) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (take1 && p1_last) x1_d = 1'b1;
    if (take2 && p2_last) x2_d = 1'b1;

    if (emit) begin
      cv_d  = 1'b1;
      ck_d  = emit_src ? p2_key : p1_key;
      cg_d  = emit_src ? p2_gene : p1_gene;
      cs_d  = emit_src;
      cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bias_q  <= 1'b0;
      x1_q    <= 1'b0;
      x2_q    <= 1'b0;
      lfsr_q  <= LFSR_SEED;
      cv_q    <= 1'b0;
      ck_q    <= '0;
      cg_q    <= '0;
      cs_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bias_q  <= bias_d;
      x1_q    <= x1_d;
      x2_q    <= x2_d;
      lfsr_q  <= lfsr_d;
      cv_q    <= cv_d;
      ck_q    <= ck_d;
      cg_q    <= cg_d;
      cs_q    <= cs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign p1_ready    = take1;
  assign p2_ready    = take2;
  assign child_valid = cv_q;
  assign child_key   = ck_q;
  assign child_gene  = cg_q;
  assign child_src   = cs_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign child_count = cnt_q;

endmodule

// File: tb/tb_crossover_gene_merge.sv
// Scoreboard bench for crossover_gene_merge: directed parent streams with hand-derived
// expected children, checked by an independent output monitor.
module tb_crossover_gene_merge;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        bias;
  logic        p1_valid, p1_ready, p1_last;
  logic [15:0] p1_key;
  logic [63:0] p1_gene;
  logic        p2_valid, p2_ready, p2_last;
  logic [15:0] p2_key;
  logic [63:0] p2_gene;
  logic        child_valid, child_ready, child_src;
  logic [15:0] child_key;
  logic [63:0] child_gene;
  logic        busy, done;
  logic [7:0]  child_count;

  crossover_gene_merge dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bias(bias),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_key(p1_key), .p1_gene(p1_gene), .p1_last(p1_last),
    .p2_valid(p2_valid), .p2_ready(p2_ready), .p2_key(p2_key), .p2_gene(p2_gene), .p2_last(p2_last),
    .child_valid(child_valid), .child_ready(child_ready), .child_key(child_key),
    .child_gene(child_gene), .child_src(child_src),
    .busy(busy), .done(done), .child_count(child_count)
  );

  typedef struct packed {
    logic [15:0] key;
    logic [63:0] gene;
    logic        src;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] k1_q[$];
  logic [15:0] k2_q[$];
  int          checks = 0;
  int          passes = 0;
  int          cons1, cons2;
  bit          abort = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] g1(input logic [15:0] k);
    return {16'h1111, 32'h0, k};
  endfunction

  function automatic logic [63:0] g2(input logic [15:0] k);
    return {16'h2222, 32'h0, k};
  endfunction

  function automatic exp_t mk(input logic [15:0] k, input logic src);
    exp_t e;
    e.key  = k;
    e.gene = src ? g2(k) : g1(k);
    e.src  = src;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Output monitor: every accepted child is compared against the head of the scoreboard.
  always @(negedge clk) begin
    if (child_valid === 1'b1 && child_ready === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_child: got key %0h src %0b, none expected", child_key, child_src);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (child_key === e.key && child_gene === e.gene && child_src === e.src) passes++;
        else $display("FAIL child: got key %0h gene %0h src %0b expected key %0h gene %0h src %0b",
                      child_key, child_gene, child_src, e.key, e.gene, e.src);
      end
    end
  end

  task automatic drv1();
    bit got;
    cons1 = 0;
    for (int i = 0; i < k1_q.size(); i++) begin
      p1_valid = 1'b1;
      p1_key   = k1_q[i];
      p1_gene  = g1(k1_q[i]);
      p1_last  = (i == k1_q.size() - 1);
      got = 1'b0;
      for (int w = 0; w < 200 && !got && !abort; w++) begin
        @(negedge clk);
        if (p1_ready) got = 1'b1;
      end
      if (!got) begin
        if (!abort) chk("p1_timeout", 64'(i), 64'(k1_q.size()));
        p1_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      cons1++;
    end
    p1_valid = 1'b0;
  endtask

  task automatic drv2();
    bit got;
    cons2 = 0;
    for (int i = 0; i < k2_q.size(); i++) begin
      p2_valid = 1'b1;
      p2_key   = k2_q[i];
      p2_gene  = g2(k2_q[i]);
      p2_last  = (i == k2_q.size() - 1);
      got = 1'b0;
      for (int w = 0; w < 200 && !got && !abort; w++) begin
        @(negedge clk);
        if (p2_ready) got = 1'b1;
      end
      if (!got) begin
        if (!abort) chk("p2_timeout", 64'(i), 64'(k2_q.size()));
        p2_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      cons2++;
    end
    p2_valid = 1'b0;
  endtask

  // mode 0: plain run, 1: 5-cycle child backpressure, 2: reset after two children.
  task automatic control(input logic b, input int mode, input int exp_cnt);
    int ndone;
    int seen;
    bit ok;
    @(posedge clk); #1;
    start = 1'b1;
    bias  = b;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'(1));
    if (mode == 1) begin
      ok = 1'b0;
      for (int c = 0; c < 100 && !ok; c++) begin
        @(negedge clk);
        if (child_valid) ok = 1'b1;
      end
      chk("first_child_seen", 64'(ok), 64'(1));
      @(posedge clk); #1;
      child_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        chk("stall_valid", 64'(child_valid), 64'(1));
        chk("stall_key", 64'(child_key), 64'(3));
        chk("stall_gene", child_gene, g1(16'd3));
        chk("stall_no_xfer", 64'({p1_ready, p2_ready}), 64'(0));
      end
      @(posedge clk); #1;
      child_ready = 1'b1;
    end
    if (mode == 2) begin
      ok = 1'b0;
      for (int c = 0; c < 100 && !ok; c++) begin
        @(negedge clk);
        if (child_count == 8'd2) ok = 1'b1;
      end
      chk("two_children", 64'(ok), 64'(1));
      rst_n = 1'b0;
      abort = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("rst_mid_valid", 64'(child_valid), 64'(0));
      chk("rst_mid_busy", 64'(busy), 64'(0));
      chk("rst_mid_count", 64'(child_count), 64'(0));
      chk("rst_mid_ready", 64'({p1_ready, p2_ready}), 64'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;
      return;
    end
    ndone = 0;
    seen  = -1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (seen < 0) seen = c;
      end
      if (seen >= 0 && c >= seen + 3) break;
    end
    chk("done_pulses", 64'(ndone), 64'(1));
    chk("child_count", 64'(child_count), 64'(exp_cnt));
    chk("busy_idle", 64'(busy), 64'(0));
    chk("sb_drained", 64'(sb.size()), 64'(0));
  endtask

  task automatic run(input logic b, input int mode, input int exp_cnt);
    abort = 1'b0;
    fork
      drv1();
      drv2();
      control(b, mode, exp_cnt);
    join
    abort = 1'b0;
  endtask

  task automatic load_match();
    k1_q = '{16'd1, 16'd2, 16'd3, 16'd4};
    k2_q = '{16'd1, 16'd2, 16'd3, 16'd4};
  endtask

  task automatic load_disjoint();
    k1_q = '{16'd1, 16'd3, 16'd5};
    k2_q = '{16'd2, 16'd3, 16'd9, 16'd10};
  endtask

  task automatic push_match();
    // LFSR A5,4A,95 exceed HALF -> ~bias (p2); 2A does not -> bias (p1)
    sb.push_back(mk(16'd1, 1'b1));
    sb.push_back(mk(16'd2, 1'b1));
    sb.push_back(mk(16'd3, 1'b1));
    sb.push_back(mk(16'd4, 1'b0));
  endtask

  task automatic push_disjoint();
    sb.push_back(mk(16'd2, 1'b1));
    sb.push_back(mk(16'd3, 1'b0));
    sb.push_back(mk(16'd9, 1'b1));
    sb.push_back(mk(16'd10, 1'b1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; bias = 1'b0; child_ready = 1'b1;
    p1_valid = 1'b0; p1_key = '0; p1_gene = '0; p1_last = 1'b0;
    p2_valid = 1'b0; p2_key = '0; p2_gene = '0; p2_last = 1'b0;

    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      p1_valid = 1'($urandom);
      p2_valid = 1'($urandom);
      p1_key   = 16'($urandom);
      p2_key   = 16'($urandom);
      p1_last  = 1'($urandom);
      p2_last  = 1'($urandom);
      start    = 1'($urandom);
      @(negedge clk);
      chk("rst_no_ready", 64'({p1_ready, p2_ready}), 64'(0));
    end
    chk("rst_child_valid", 64'(child_valid), 64'(0));
    chk("rst_child_key", 64'(child_key), 64'(0));
    chk("rst_child_gene", child_gene, 64'(0));
    chk("rst_child_src", 64'(child_src), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_count", 64'(child_count), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1; start = 1'b0; p1_valid = 1'b0; p2_valid = 1'b0;

    load_match();
    push_match();
    run(1'b0, 0, 4);

    load_disjoint();
    push_disjoint();
    run(1'b1, 0, 4);

    load_disjoint();
    push_disjoint();
    run(1'b1, 1, 4);

    k1_q = '{16'd7};
    k2_q = '{16'd1, 16'd2};
    sb.push_back(mk(16'd7, 1'b0));
    run(1'b0, 0, 1);
    chk("fitter_absent_p2_consumed", 64'(cons2), 64'(2));
    chk("fitter_absent_p1_consumed", 64'(cons1), 64'(1));

    load_match();
    sb.push_back(mk(16'd1, 1'b1));
    sb.push_back(mk(16'd2, 1'b1));
    run(1'b0, 2, 0);
    chk("mid_reset_sb_drained", 64'(sb.size()), 64'(0));
    sb.delete();

    load_match();
    push_match();
    run(1'b0, 0, 4);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
